// File: rtl/multicycle_pkg.sv
// Shared types and constants for the multi-cycle RV32I control FSM.
package multicycle_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    EXEC_R   = 4'd2,
    EXEC_I   = 4'd3,
    WB_ALU   = 4'd4,
    MEM_ADDR = 4'd5,
    MEM_RD   = 4'd6,
    MEM_WR   = 4'd7,
    WB_MEM   = 4'd8,
    BRANCH   = 4'd9,
    JAL      = 4'd10,
    TRAP     = 4'd11
  } state_t;

  typedef enum logic [1:0] {
    SRC_A_PC     = 2'd0,
    SRC_A_RS1    = 2'd1,
    SRC_A_OLD_PC = 2'd2
  } src_a_t;

  typedef enum logic [1:0] {
    SRC_B_RS2  = 2'd0,
    SRC_B_IMM  = 2'd1,
    SRC_B_FOUR = 2'd2
  } src_b_t;

  typedef enum logic [1:0] {
    RES_ALU     = 2'd0,
    RES_MEM     = 2'd1,
    RES_ALU_REG = 2'd2
  } result_src_t;

  typedef struct packed {
    logic        mem_req;
    logic        mem_we;
    logic        ir_write;
    logic        pc_write;
    logic        reg_write;
    src_a_t      alu_src_a;
    src_b_t      alu_src_b;
    result_src_t result_src;
    logic        trap;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '{
    mem_req:    1'b0,
    mem_we:     1'b0,
    ir_write:   1'b0,
    pc_write:   1'b0,
    reg_write:  1'b0,
    alu_src_a:  SRC_A_PC,
    alu_src_b:  SRC_B_RS2,
    result_src: RES_ALU,
    trap:       1'b0
  };

  // Only BEQ and BNE are resolved; every other funct3 falls through as not taken.
  function automatic logic branch_taken(input logic [2:0] funct3, input logic zero);
    return ((funct3 == F3_BEQ) && zero) || ((funct3 == F3_BNE) && !zero);
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Control bundle between the multi-cycle controller (master) and the datapath/memory (slave).
interface multicycle_controller_if;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       zero;
  logic       mem_ready;
  logic       mem_req;
  logic       mem_we;
  logic       ir_write;
  logic       pc_write;
  logic       reg_write;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] result_src;
  logic       trap;
  logic [3:0] state_o;

  modport master (
    input  opcode, funct3, zero, mem_ready,
    output mem_req, mem_we, ir_write, pc_write, reg_write,
    output alu_src_a, alu_src_b, result_src, trap, state_o
  );

  modport slave (
    output opcode, funct3, zero, mem_ready,
    input  mem_req, mem_we, ir_write, pc_write, reg_write,
    input  alu_src_a, alu_src_b, result_src, trap, state_o
  );

endinterface

// File: rtl/mem_wait_timer.sv
// Counts memory wait cycles for the current request and flags a timeout.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16,
  parameter int TO_W        = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_req,
  input  logic i_ready,
  output logic o_timeout
);

  localparam logic [TO_W-1:0] LP_LIMIT = TO_W'(MEM_TIMEOUT);

  logic [TO_W-1:0] r_count;
  logic            w_at_limit;

  assign w_at_limit = (r_count == LP_LIMIT);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_count <= '0;
    end else if (i_req && !i_ready && !w_at_limit) begin
      r_count <= r_count + TO_W'(1);
    end
  end

  // A ready arriving in the limit cycle still completes the access.
  assign o_timeout = i_req && !i_ready && w_at_limit;

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM of the multi-cycle RV32I core (FETCH/DECODE/EXECUTE/MEM/WB).
// Optional performance counters are built when MULTICYCLE_PERF_EN is defined.
module multicycle_controller
  import multicycle_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int TO_W        = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  multicycle_controller_if.master bus
`ifdef MULTICYCLE_PERF_EN
  ,
  output logic [31:0]             cycle_cnt,
  output logic [31:0]             instret_cnt,
  output logic [31:0]             stall_cnt
`endif
);

  state_t r_state;
  state_t w_state_next;
  ctrl_t  w_ctrl;
  logic   w_timeout;
  logic   w_run;

  assign w_run = !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= FETCH;
    end else begin
      r_state <= w_state_next;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_ctrl       = CTRL_IDLE;
    unique case (r_state)
      FETCH: begin
        w_ctrl.mem_req   = 1'b1;
        w_ctrl.alu_src_a = SRC_A_PC;
        w_ctrl.alu_src_b = SRC_B_FOUR;
        if (bus.mem_ready) begin
          w_ctrl.ir_write = 1'b1;
          w_ctrl.pc_write = 1'b1;
          w_state_next    = DECODE;
        end else if (w_timeout) begin
          w_state_next = TRAP;
        end
      end
      DECODE: begin
        // PC already holds PC+4 here, so the branch/jump target is built from the old PC.
        w_ctrl.alu_src_a = SRC_A_OLD_PC;
        w_ctrl.alu_src_b = SRC_B_IMM;
        case (bus.opcode)
          OP_R:              w_state_next = EXEC_R;
          OP_I:              w_state_next = EXEC_I;
          OP_LOAD, OP_STORE: w_state_next = MEM_ADDR;
          OP_BRANCH:         w_state_next = BRANCH;
          OP_JAL:            w_state_next = JAL;
          default:           w_state_next = TRAP;
        endcase
      end
      EXEC_R: begin
        w_ctrl.alu_src_a = SRC_A_RS1;
        w_ctrl.alu_src_b = SRC_B_RS2;
        w_state_next     = WB_ALU;
      end
      EXEC_I: begin
        w_ctrl.alu_src_a = SRC_A_RS1;
        w_ctrl.alu_src_b = SRC_B_IMM;
        w_state_next     = WB_ALU;
      end
      WB_ALU: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.result_src = RES_ALU_REG;
        w_state_next      = FETCH;
      end
      MEM_ADDR: begin
        w_ctrl.alu_src_a = SRC_A_RS1;
        w_ctrl.alu_src_b = SRC_B_IMM;
        w_state_next     = (bus.opcode == OP_LOAD) ? MEM_RD : MEM_WR;
      end
      MEM_RD: begin
        w_ctrl.mem_req    = 1'b1;
        w_ctrl.result_src = RES_ALU_REG;
        if (bus.mem_ready) begin
          w_state_next = WB_MEM;
        end else if (w_timeout) begin
          w_state_next = TRAP;
        end
      end
      MEM_WR: begin
        w_ctrl.mem_req = 1'b1;
        w_ctrl.mem_we  = 1'b1;
        if (bus.mem_ready) begin
          w_state_next = FETCH;
        end else if (w_timeout) begin
          w_state_next = TRAP;
        end
      end
      WB_MEM: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.result_src = RES_MEM;
        w_state_next      = FETCH;
      end
      BRANCH: begin
        w_ctrl.alu_src_a  = SRC_A_RS1;
        w_ctrl.alu_src_b  = SRC_B_RS2;
        w_ctrl.result_src = RES_ALU_REG;
        w_ctrl.pc_write   = branch_taken(bus.funct3, bus.zero);
        w_state_next      = FETCH;
      end
      JAL: begin
        w_ctrl.alu_src_a  = SRC_A_OLD_PC;
        w_ctrl.alu_src_b  = SRC_B_FOUR;
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.result_src = RES_ALU;
        w_ctrl.pc_write   = 1'b1;
        w_state_next      = FETCH;
      end
      TRAP: begin
        w_ctrl.trap  = 1'b1;
        w_state_next = TRAP;
      end
      default: begin
        w_state_next = TRAP;
      end
    endcase
  end

  // Any state change opens a fresh wait window for the next request.
  mem_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .TO_W        (TO_W)
  ) u_mem_wait_timer (
    .clk       (clk),
    .reset     (reset),
    .i_clear   (w_state_next != r_state),
    .i_req     (w_ctrl.mem_req),
    .i_ready   (bus.mem_ready),
    .o_timeout (w_timeout)
  );

  // Reset masks every strobe combinationally so an aborted access never leaks a write.
  assign bus.mem_req    = w_ctrl.mem_req   && w_run;
  assign bus.mem_we     = w_ctrl.mem_we    && w_run;
  assign bus.ir_write   = w_ctrl.ir_write  && w_run;
  assign bus.pc_write   = w_ctrl.pc_write  && w_run;
  assign bus.reg_write  = w_ctrl.reg_write && w_run;
  assign bus.trap       = w_ctrl.trap      && w_run;
  assign bus.alu_src_a  = w_run ? w_ctrl.alu_src_a  : 2'd0;
  assign bus.alu_src_b  = w_run ? w_ctrl.alu_src_b  : 2'd0;
  assign bus.result_src = w_run ? w_ctrl.result_src : 2'd0;
  assign bus.state_o    = r_state;

`ifdef MULTICYCLE_PERF_EN
  logic [31:0] r_cycle_cnt;
  logic [31:0] r_instret_cnt;
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cycle_cnt   <= '0;
      r_instret_cnt <= '0;
      r_stall_cnt   <= '0;
    end else begin
      if (r_state != TRAP) begin
        r_cycle_cnt <= r_cycle_cnt + 32'd1;
      end
      if ((r_state != FETCH) && (w_state_next == FETCH)) begin
        r_instret_cnt <= r_instret_cnt + 32'd1;
      end
      if (w_ctrl.mem_req && !bus.mem_ready) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
    end
  end

  assign cycle_cnt   = r_cycle_cnt;
  assign instret_cnt = r_instret_cnt;
  assign stall_cnt   = r_stall_cnt;
`endif

endmodule
